classifier_feeder: RTL and testbench

Initiator-side front end for the rule classifier. It accepts 5-tuple packets on a valid/ready stream, buffers them in a small FIFO and tags them. It issues them one at a time over the classifier's single-cycle-valid / ready_to_process protocol, then captures the matched rule's first/last fields and returns each result, in order, on a valid/ready result stream. It sits between the packet ingress and the classifier and also supervises the classifier with a per-packet timeout.

---
 rtl/network_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 45 ++++
 rtl/classifier_feeder.sv | 197 +++++++++++++++++++
 tb/tb_classifier_feeder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/network_pkg.sv
// Shared types for the classifier front end: packet payload, feeder FSM states
// and the captured-result record.
package network_pkg;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  protocol;
  } packet_s;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    OUTPUT,
    DRAIN
  } feeder_state_e;

  // The tag lives in its own TAG_W-wide register next to this record.
  typedef struct packed {
    packet_s first;
    packet_s last;
    logic    timeout;
  } feeder_result_s;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; a pop makes room for a push in the
// same cycle even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/classifier_feeder.sv
// Buffers tagged 5-tuple packets, issues them one at a time to the rule
// classifier, supervises it with a timeout and returns results in order.
module classifier_feeder
  import network_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_src_ip,
  input  logic [31:0]      in_dst_ip,
  input  logic [15:0]      in_src_port,
  input  logic [15:0]      in_dst_port,
  input  logic [7:0]       in_protocol,
  output logic             cls_input_is_valid,
  output logic [31:0]      cls_src_ip,
  output logic [31:0]      cls_dst_ip,
  output logic [15:0]      cls_src_port,
  output logic [15:0]      cls_dst_port,
  output logic [7:0]       cls_protocol,
  input  logic             cls_ready_to_process,
  input  logic [31:0]      cls_first_src_ip,
  input  logic [31:0]      cls_first_dst_ip,
  input  logic [15:0]      cls_first_src_port,
  input  logic [15:0]      cls_first_dst_port,
  input  logic [7:0]       cls_first_protocol,
  input  logic [31:0]      cls_last_src_ip,
  input  logic [31:0]      cls_last_dst_ip,
  input  logic [15:0]      cls_last_src_port,
  input  logic [15:0]      cls_last_dst_port,
  input  logic [7:0]       cls_last_protocol,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_first_src_ip,
  output logic [31:0]      res_first_dst_ip,
  output logic [15:0]      res_first_src_port,
  output logic [15:0]      res_first_dst_port,
  output logic [7:0]       res_first_protocol,
  output logic [31:0]      res_last_src_ip,
  output logic [31:0]      res_last_dst_ip,
  output logic [15:0]      res_last_src_port,
  output logic [15:0]      res_last_dst_port,
  output logic [7:0]       res_last_protocol,
  output logic             res_timeout,
  output logic             timeout_sticky
);

  localparam int TCW = $clog2(TIMEOUT);

  typedef struct packed {
    packet_s          pkt;
    logic [TAG_W-1:0] tag;
  } entry_t;

  feeder_state_e    state;
  entry_t           fifo_din;
  entry_t           fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] issue_tag;
  packet_s          issue_pkt;
  packet_s          cls_first;
  packet_s          cls_last;
  feeder_result_s   result;
  logic             drain;
  logic             busy_wait;
  logic [TCW-1:0]   tcnt;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign pop       = (state == IDLE) && !fifo_empty && cls_ready_to_process;
  assign fifo_din  = {in_src_ip, in_dst_ip, in_src_port, in_dst_port, in_protocol, tag_cnt};
  assign cls_first = {cls_first_src_ip, cls_first_dst_ip, cls_first_src_port,
                      cls_first_dst_port, cls_first_protocol};
  assign cls_last  = {cls_last_src_ip, cls_last_dst_ip, cls_last_src_port,
                      cls_last_dst_port, cls_last_protocol};

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tag_cnt <= '0;
    else if (push) tag_cnt <= tag_cnt + 1'b1;
  end

  // After a timeout the classifier is still busy with the abandoned packet, so
  // the drain flag routes OUTPUT through DRAIN before any new issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      cls_input_is_valid <= 1'b0;
      issue_pkt          <= '0;
      issue_tag          <= '0;
      result             <= '0;
      res_tag            <= '0;
      res_valid          <= 1'b0;
      timeout_sticky     <= 1'b0;
      drain              <= 1'b0;
      busy_wait          <= 1'b0;
      tcnt               <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            issue_pkt          <= fifo_dout.pkt;
            issue_tag          <= fifo_dout.tag;
            cls_input_is_valid <= 1'b1;
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          cls_input_is_valid <= 1'b0;
          busy_wait          <= 1'b0;
          state              <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!cls_ready_to_process) begin
            tcnt  <= '0;
            state <= WAIT_DONE;
          end else if (busy_wait) begin
            cls_input_is_valid <= 1'b1;
            state              <= ISSUE;
          end else begin
            busy_wait <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (cls_ready_to_process) begin
            result    <= '{first: cls_first, last: cls_last, timeout: 1'b0};
            res_tag   <= issue_tag;
            res_valid <= 1'b1;
            state     <= OUTPUT;
          end else if (tcnt == TCW'(TIMEOUT - 1)) begin
            result         <= '{first: '0, last: '0, timeout: 1'b1};
            res_tag        <= issue_tag;
            res_valid      <= 1'b1;
            timeout_sticky <= 1'b1;
            drain          <= 1'b1;
            state          <= OUTPUT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= drain ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          if (cls_ready_to_process) begin
            drain <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cls_src_ip         = issue_pkt.src_ip;
  assign cls_dst_ip         = issue_pkt.dst_ip;
  assign cls_src_port       = issue_pkt.src_port;
  assign cls_dst_port       = issue_pkt.dst_port;
  assign cls_protocol       = issue_pkt.protocol;
  assign res_first_src_ip   = result.first.src_ip;
  assign res_first_dst_ip   = result.first.dst_ip;
  assign res_first_src_port = result.first.src_port;
  assign res_first_dst_port = result.first.dst_port;
  assign res_first_protocol = result.first.protocol;
  assign res_last_src_ip    = result.last.src_ip;
  assign res_last_dst_ip    = result.last.dst_ip;
  assign res_last_src_port  = result.last.src_port;
  assign res_last_dst_port  = result.last.dst_port;
  assign res_last_protocol  = result.last.protocol;
  assign res_timeout        = result.timeout;

endmodule

// File: tb/tb_classifier_feeder.sv
// Self-checking bench for classifier_feeder: a behavioural classifier responder
// plus an in-order scoreboard of pushed packets.
module tb_classifier_feeder;
  import network_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W      = 2;
  localparam int TIMEOUT    = 8;
  localparam int TAG_MOD    = 1 << TAG_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  packet_s          in_pkt;
  logic             cls_input_is_valid;
  logic [31:0]      cls_src_ip, cls_dst_ip;
  logic [15:0]      cls_src_port, cls_dst_port;
  logic [7:0]       cls_protocol;
  logic             cls_ready = 1'b1;
  packet_s          model_first = '0;
  packet_s          model_last = '0;
  logic             res_valid;
  logic             res_ready;
  logic [TAG_W-1:0] res_tag;
  logic [31:0]      res_first_src_ip, res_first_dst_ip, res_last_src_ip, res_last_dst_ip;
  logic [15:0]      res_first_src_port, res_first_dst_port, res_last_src_port, res_last_dst_port;
  logic [7:0]       res_first_protocol, res_last_protocol;
  logic             res_timeout;
  logic             timeout_sticky;

  classifier_feeder #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TAG_W      (TAG_W),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_src_ip            (in_pkt.src_ip),
    .in_dst_ip            (in_pkt.dst_ip),
    .in_src_port          (in_pkt.src_port),
    .in_dst_port          (in_pkt.dst_port),
    .in_protocol          (in_pkt.protocol),
    .cls_input_is_valid   (cls_input_is_valid),
    .cls_src_ip           (cls_src_ip),
    .cls_dst_ip           (cls_dst_ip),
    .cls_src_port         (cls_src_port),
    .cls_dst_port         (cls_dst_port),
    .cls_protocol         (cls_protocol),
    .cls_ready_to_process (cls_ready),
    .cls_first_src_ip     (model_first.src_ip),
    .cls_first_dst_ip     (model_first.dst_ip),
    .cls_first_src_port   (model_first.src_port),
    .cls_first_dst_port   (model_first.dst_port),
    .cls_first_protocol   (model_first.protocol),
    .cls_last_src_ip      (model_last.src_ip),
    .cls_last_dst_ip      (model_last.dst_ip),
    .cls_last_src_port    (model_last.src_port),
    .cls_last_dst_port    (model_last.dst_port),
    .cls_last_protocol    (model_last.protocol),
    .res_valid            (res_valid),
    .res_ready            (res_ready),
    .res_tag              (res_tag),
    .res_first_src_ip     (res_first_src_ip),
    .res_first_dst_ip     (res_first_dst_ip),
    .res_first_src_port   (res_first_src_port),
    .res_first_dst_port   (res_first_dst_port),
    .res_first_protocol   (res_first_protocol),
    .res_last_src_ip      (res_last_src_ip),
    .res_last_dst_ip      (res_last_dst_ip),
    .res_last_src_port    (res_last_src_port),
    .res_last_dst_port    (res_last_dst_port),
    .res_last_protocol    (res_last_protocol),
    .res_timeout          (res_timeout),
    .timeout_sticky       (timeout_sticky)
  );

  typedef struct {
    packet_s pkt;
    int      tag;
  } exp_t;

  exp_t exp_q[$];
  int   tag_next = 0;
  int   tests = 0;
  int   failed = 0;
  int   strobes = 0;
  int   lat_min = 2;
  int   lat_max = 6;
  bit   hang = 1'b0;
  int   ignore_req = 0;
  int   ignored = 0;
  int   busy_left = 0;
  packet_s held = '0;

  // The rule the classifier model "matches": a /24 source, /16 destination
  // and a 256-wide source port window around the packet.
  function automatic packet_s ruleFirst(input packet_s p);
    return '{src_ip: p.src_ip & 32'hFFFF_FF00, dst_ip: p.dst_ip & 32'hFFFF_0000,
             src_port: p.src_port & 16'hFF00, dst_port: p.dst_port, protocol: p.protocol};
  endfunction

  function automatic packet_s ruleLast(input packet_s p);
    return '{src_ip: p.src_ip | 32'h0000_00FF, dst_ip: p.dst_ip | 32'h0000_FFFF,
             src_port: p.src_port | 16'h00FF, dst_port: p.dst_port, protocol: p.protocol};
  endfunction

  function automatic packet_s randPacket();
    return '{src_ip: $urandom, dst_ip: $urandom, src_port: 16'($urandom),
             dst_port: 16'($urandom), protocol: 8'($urandom)};
  endfunction

  // Classifier model, evaluated on the falling edge so it never races the DUT.
  always @(negedge clk) begin
    if (!reset_n) begin
      cls_ready = 1'b1;
      busy_left = 0;
    end else if (cls_ready) begin
      if (cls_input_is_valid) begin
        if (ignore_req != ignored) begin
          ignored = ignored + 1;
        end else begin
          cls_ready = 1'b0;
          busy_left = $urandom_range(lat_max, lat_min);
          held = {cls_src_ip, cls_dst_ip, cls_src_port, cls_dst_port, cls_protocol};
        end
      end
    end else if (!hang) begin
      if (busy_left <= 1) begin
        cls_ready   = 1'b1;
        model_first = ruleFirst(held);
        model_last  = ruleLast(held);
      end else begin
        busy_left = busy_left - 1;
      end
    end
  end

  always @(posedge clk) if (cls_input_is_valid) strobes <= strobes + 1;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string name, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input packet_s p);
    int guard = 0;
    in_pkt   = p;
    in_valid = 1'b1;
    while (!in_ready && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      checkValue("in_ready_wait", 128'(in_ready), 128'(1));
    end else begin
      @(posedge clk); #1;
      exp_q.push_back('{pkt: p, tag: tag_next % TAG_MOD});
      tag_next++;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitValid();
    int guard = 0;
    while (!res_valid && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  task automatic waitStrobe();
    int guard = 0;
    while (!cls_input_is_valid && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkValue("strobe_seen", 128'(cls_input_is_valid), 128'(1));
  endtask

  task automatic peekCheck(input bit exp_to);
    exp_t e;
    checkValue("res_valid", 128'(res_valid), 128'(1));
    if (exp_q.size() == 0) begin
      checkValue("scoreboard_empty", 128'(exp_q.size()), 128'(1));
    end else begin
      e = exp_q[0];
      checkValue("res_tag", 128'(res_tag), 128'(e.tag));
      checkValue("res_timeout", 128'(res_timeout), 128'(exp_to));
      checkValue("res_first", 128'({res_first_src_ip, res_first_dst_ip, res_first_src_port,
                 res_first_dst_port, res_first_protocol}),
                 exp_to ? 128'(0) : 128'(ruleFirst(e.pkt)));
      checkValue("res_last", 128'({res_last_src_ip, res_last_dst_ip, res_last_src_port,
                 res_last_dst_port, res_last_protocol}),
                 exp_to ? 128'(0) : 128'(ruleLast(e.pkt)));
      checkValue("cls_pkt", 128'({cls_src_ip, cls_dst_ip, cls_src_port, cls_dst_port,
                 cls_protocol}), 128'(e.pkt));
    end
  endtask

  task automatic checkOutput(input bit exp_to);
    waitValid();
    peekCheck(exp_to);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  initial begin
    packet_s p;
    int      base;
    int      n;
    bit      saw_full;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_pkt   = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkValue("rst_in_ready", 128'(in_ready), 128'(1));
    checkValue("rst_strobe", 128'(cls_input_is_valid), 128'(0));
    checkValue("rst_cls_pkt", 128'({cls_src_ip, cls_dst_ip, cls_src_port, cls_dst_port, cls_protocol}), 128'(0));
    checkValue("rst_res_valid", 128'(res_valid), 128'(0));
    checkValue("rst_res_fields", 128'({res_tag, res_first_src_ip, res_last_src_ip, res_timeout}), 128'(0));
    checkValue("rst_sticky", 128'(timeout_sticky), 128'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single packet, classifier answers after 5 cycles; issue 2 edges after enqueue.
    lat_min = 5; lat_max = 5;
    base = strobes;
    p = '{src_ip: 32'h0A00_0001, dst_ip: 32'h0A00_0002, src_port: 16'd80, dst_port: 16'd443, protocol: 8'd6};
    applyStimulus(p);
    checkValue("issue_latency_pre", 128'(cls_input_is_valid), 128'(0));
    @(posedge clk); #1;
    checkValue("issue_latency", 128'(cls_input_is_valid), 128'(1));
    checkOutput(1'b0);
    checkValue("single_strobe", 128'(strobes - base), 128'(1));
    checkValue("t1_first_src", 128'(ruleFirst(p).src_ip), 128'(32'h0A00_0000));

    // Classifier ignores the first strobe: the feeder must re-strobe.
    lat_min = 2; lat_max = 6;
    base = strobes;
    ignore_req++;
    applyStimulus(randPacket());
    checkOutput(1'b0);
    checkValue("restrobe_count", 128'(strobes - base), 128'(2));

    // Six back-to-back packets; FIFO must fill while one is in flight.
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          applyStimulus(randPacket());
          if (!in_ready) saw_full = 1'b1;
        end
      end
      begin
        for (int i = 0; i < 6; i++) checkOutput(1'b0);
      end
    join
    checkValue("b2b_saw_full", 128'(saw_full), 128'(1));

    // Hung classifier: timeout after TIMEOUT wait cycles, then drain.
    hang = 1'b1;
    applyStimulus(randPacket());
    waitStrobe();
    n = 0;
    while (!res_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checkValue("timeout_cycles", 128'(n), 128'(TIMEOUT + 2));
    checkOutput(1'b1);
    checkValue("sticky_set", 128'(timeout_sticky), 128'(1));
    base = strobes;
    applyStimulus(randPacket());
    repeat (6) @(posedge clk);
    #1;
    checkValue("drain_no_issue", 128'(strobes - base), 128'(0));
    hang = 1'b0;
    checkOutput(1'b0);
    checkValue("drain_then_issue", 128'(strobes - base), 128'(1));
    checkValue("sticky_held", 128'(timeout_sticky), 128'(1));

    // Back-pressure: result held ~20 cycles while the FIFO fills.
    applyStimulus(randPacket());
    waitValid();
    base = strobes;
    peekCheck(1'b0);
    for (int i = 0; i < FIFO_DEPTH; i++) applyStimulus(randPacket());
    checkValue("bp_in_ready", 128'(in_ready), 128'(0));
    repeat (20 - FIFO_DEPTH) @(posedge clk);
    #1;
    peekCheck(1'b0);
    checkValue("bp_no_strobe", 128'(strobes - base), 128'(0));
    for (int i = 0; i <= FIFO_DEPTH; i++) checkOutput(1'b0);

    // Reset in WAIT_DONE: everything returns to reset values, tags restart.
    lat_min = 40; lat_max = 40;
    applyStimulus(randPacket());
    waitStrobe();
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkValue("mid_rst_strobe", 128'(cls_input_is_valid), 128'(0));
    checkValue("mid_rst_cls_pkt", 128'({cls_src_ip, cls_dst_ip, cls_src_port, cls_dst_port, cls_protocol}), 128'(0));
    checkValue("mid_rst_res", 128'({res_valid, res_tag, res_timeout, res_first_src_ip}), 128'(0));
    checkValue("mid_rst_sticky", 128'(timeout_sticky), 128'(0));
    checkValue("mid_rst_in_ready", 128'(in_ready), 128'(1));
    exp_q.delete();
    tag_next = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    lat_min = 2; lat_max = 6;
    @(posedge clk); #1;

    // Five packets after reset: tags 0,1,2,3,0 with TAG_W=2.
    fork
      begin
        for (int i = 0; i < 5; i++) applyStimulus(randPacket());
      end
      begin
        for (int i = 0; i < 5; i++) checkOutput(1'b0);
      end
    join

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
